// File: rtl/msu_audio_player_if.sv
// FIFO read port and stereo sample output of the MSU audio player.
// The master side is the player; the slave side is the FIFO and mixer.
interface msu_audio_player_if #(
  parameter int unsigned USEDW_W = 12
);
  logic               fifo_rdreq;
  logic [15:0]        fifo_rdata;
  logic [USEDW_W-1:0] fifo_usedw;
  logic [15:0]        audio_l;
  logic [15:0]        audio_r;
  logic               audio_valid;

  modport master (
    output fifo_rdreq,
    input  fifo_rdata,
    input  fifo_usedw,
    output audio_l,
    output audio_r,
    output audio_valid
  );

  modport slave (
    input  fifo_rdreq,
    output fifo_rdata,
    output fifo_usedw,
    input  audio_l,
    input  audio_r,
    input  audio_valid
  );
endinterface

// File: rtl/msu_audio_player.sv
// MSU audio player: pops one L/R PCM pair per sample tick from the audio FIFO, applies a
// ramped 8-bit volume and presents a registered stereo sample. Emits silence when idle,
// priming or starved.
module msu_audio_player #(
  parameter int unsigned PRIME_WORDS = 512,
  parameter int unsigned VOL_STEP    = 1,
  parameter int unsigned USEDW_W     = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_sample_tick,
  input  logic                i_play_en,
  input  logic                i_flush,
  input  logic [7:0]          i_volume,
  msu_audio_player_if.master  bus,
  output logic                o_playing,
  output logic                o_underflow,
  output logic [15:0]         o_underflow_cnt
);

  typedef enum logic [2:0] {
    StIdle, StPrime, StWait, StRdL, StLatL, StRdR, StLatR, StMul
  } state_e;

  state_e r_state, w_state_nxt;

  logic [7:0]         r_vol_cur, w_vol_nxt;
  logic [15:0]        r_smp_l, r_smp_r;
  logic [15:0]        r_audio_l, r_audio_r;
  logic               r_audio_valid;
  logic               r_underflow;
  logic [15:0]        r_underflow_cnt;
  logic               w_tick, w_silence, w_uflow, w_rdreq, w_playing;
  logic [31:0]        w_usedw;
  logic [7:0]         w_step;
  logic signed [23:0] w_prod_l, w_prod_r;
  logic [15:0]        w_scaled_l, w_scaled_r;

  // A flush in the same cycle as a tick swallows the tick entirely.
  assign w_tick  = i_sample_tick & ~i_flush;
  assign w_usedw = 32'(bus.fifo_usedw);
  assign w_step  = 8'(VOL_STEP);

  // Volume ramp target for this tick: move toward i_volume by at most w_step.
  always_comb begin
    w_vol_nxt = r_vol_cur;
    if (r_vol_cur < i_volume) begin
      w_vol_nxt = ((i_volume - r_vol_cur) > w_step) ? r_vol_cur + w_step : i_volume;
    end else if (r_vol_cur > i_volume) begin
      w_vol_nxt = ((r_vol_cur - i_volume) > w_step) ? r_vol_cur - w_step : i_volume;
    end
  end

  // |product| < 2^23, so 24 bits hold it exactly; >>> 8 floors toward -inf.
  always_comb begin
    w_prod_l   = $signed({{8{r_smp_l[15]}}, r_smp_l}) * $signed({16'b0, r_vol_cur});
    w_prod_r   = $signed({{8{r_smp_r[15]}}, r_smp_r}) * $signed({16'b0, r_vol_cur});
    w_scaled_l = (r_vol_cur == 8'hFF) ? r_smp_l : 16'(w_prod_l >>> 8);
    w_scaled_r = (r_vol_cur == 8'hFF) ? r_smp_r : 16'(w_prod_r >>> 8);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Next state, pop strobe and silence/underflow decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_silence   = 1'b0;
    w_uflow     = 1'b0;
    w_rdreq     = 1'b0;
    w_playing   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_silence = w_tick;
        if (i_play_en) w_state_nxt = StPrime;
      end
      StPrime: begin
        w_silence = w_tick;
        if (!i_play_en)                  w_state_nxt = StIdle;
        else if (w_usedw >= PRIME_WORDS) w_state_nxt = StWait;
      end
      StWait: begin
        w_playing = 1'b1;
        if (w_tick) begin
          // Need a whole pair present so L and R are never split across ticks.
          if (w_usedw >= 32'd2) begin
            w_state_nxt = StRdL;
          end else begin
            w_silence = 1'b1;
            w_uflow   = 1'b1;
          end
        end else if (!i_play_en) begin
          w_state_nxt = StIdle;
        end
      end
      StRdL:  begin w_playing = 1'b1; w_rdreq = 1'b1; w_state_nxt = StLatL; end
      StLatL: begin w_playing = 1'b1; w_state_nxt = StRdR; end
      StRdR:  begin w_playing = 1'b1; w_rdreq = 1'b1; w_state_nxt = StLatR; end
      StLatR: begin w_playing = 1'b1; w_state_nxt = StMul; end
      StMul: begin
        w_playing   = 1'b1;
        w_state_nxt = i_play_en ? StWait : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (i_flush) begin
      w_state_nxt = StIdle;
      w_rdreq     = 1'b0;
      w_silence   = 1'b0;
      w_uflow     = 1'b0;
    end
  end

  // Datapath: volume ramp, sample capture, output registers and underflow tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vol_cur       <= 8'd0;
      r_smp_l         <= 16'd0;
      r_smp_r         <= 16'd0;
      r_audio_l       <= 16'd0;
      r_audio_r       <= 16'd0;
      r_audio_valid   <= 1'b0;
      r_underflow     <= 1'b0;
      r_underflow_cnt <= 16'd0;
    end else if (i_flush) begin
      r_audio_l       <= 16'd0;
      r_audio_r       <= 16'd0;
      r_audio_valid   <= 1'b0;
      r_underflow     <= 1'b0;
      r_underflow_cnt <= 16'd0;
    end else begin
      r_audio_valid <= 1'b0;
      if (w_tick) r_vol_cur <= w_vol_nxt;
      if (r_state == StLatL) r_smp_l <= bus.fifo_rdata;
      if (r_state == StLatR) r_smp_r <= bus.fifo_rdata;
      if (w_silence) begin
        r_audio_l     <= 16'd0;
        r_audio_r     <= 16'd0;
        r_audio_valid <= 1'b1;
      end
      if (r_state == StMul) begin
        r_audio_l     <= w_scaled_l;
        r_audio_r     <= w_scaled_r;
        r_audio_valid <= 1'b1;
      end
      if (w_uflow) begin
        r_underflow <= 1'b1;
        if (r_underflow_cnt != 16'hFFFF) r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
    end
  end

  assign bus.fifo_rdreq  = w_rdreq;
  assign bus.audio_l     = r_audio_l;
  assign bus.audio_r     = r_audio_r;
  assign bus.audio_valid = r_audio_valid;
  assign o_playing       = w_playing;
  assign o_underflow     = r_underflow;
  assign o_underflow_cnt = r_underflow_cnt;

endmodule
